// File: rtl/alu_md_unit_pkg.sv
// alu_pkg: shared types and decode for the alu_md_unit execution unit.
// The optional RV32M path is enabled by defining ALU_MD_M_EXT_EN; the decode
// helper takes that choice as an input so this package is build-independent.
package alu_pkg;

  // Internal operation code produced by decode.
  typedef enum logic [4:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_MUL,
    ALU_MULH,
    ALU_MULHSU,
    ALU_MULHU,
    ALU_DIV,
    ALU_DIVU,
    ALU_REM,
    ALU_REMU
  } alu_op_e;

  // Control FSM of the unit.
  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_HOLD
  } state_e;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Folds the old ALU-control table and the funct decode into one step.
  function automatic alu_op_e alu_decode(
    input logic [1:0] alu_op,
    input logic [2:0] funct3,
    input logic [6:0] funct7,
    input logic [6:0] opcode,
    input logic       m_en
  );
    alu_op_e op;
    op = ALU_ADD;
    case (alu_op)
      2'b01: op = ALU_SUB;
      2'b10: begin
        if (m_en && opcode == OPC_OP && funct7 == F7_MULDIV) begin
          case (funct3)
            3'b000:  op = ALU_MUL;
            3'b001:  op = ALU_MULH;
            3'b010:  op = ALU_MULHSU;
            3'b011:  op = ALU_MULHU;
            3'b100:  op = ALU_DIV;
            3'b101:  op = ALU_DIVU;
            3'b110:  op = ALU_REM;
            default: op = ALU_REMU;
          endcase
        end else begin
          case (funct3)
            // Immediate forms have no SUB, so funct7 only matters for R-type.
            3'b000:  op = (opcode == OPC_OP && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
          endcase
        end
      end
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_md_unit_if.sv
// alu_md_unit_if: valid/ready issue and result bus of alu_md_unit.
// master = decode/writeback side, slave = the execution unit.
interface alu_md_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [6:0]      opcode;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  modport master (
    output in_valid, alu_op, funct3, funct7, opcode, a, b, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, alu_op, funct3, funct7, opcode, a, b, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_md_unit_divider.sv
// alu_divider: radix-2 restoring divider, one quotient bit per cycle.
// Works on magnitudes and fixes the signs on the final step. Divide-by-zero
// and signed overflow are resolved by the parent and never started here.
// Only instantiated when ALU_MD_M_EXT_EN is defined.
module alu_divider #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_signed,
  input  logic            want_rem,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);

  logic               active;
  logic [SHAMT_W-1:0] cnt;
  logic [XLEN-1:0]    dividend;
  logic [XLEN-1:0]    divisor;
  logic [XLEN-1:0]    rem;
  logic [XLEN-1:0]    quot;
  logic               neg_q;
  logic               neg_r;
  logic               rem_sel;

  logic               a_neg;
  logic               b_neg;
  logic [XLEN-1:0]    a_abs;
  logic [XLEN-1:0]    b_abs;

  logic [XLEN:0]      partial;
  logic               ge;
  logic [XLEN-1:0]    rem_nxt;
  logic [XLEN-1:0]    quot_nxt;

  assign a_neg = is_signed & a[XLEN-1];
  assign b_neg = is_signed & b[XLEN-1];
  assign a_abs = a_neg ? -a : a;
  assign b_abs = b_neg ? -b : b;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  // NOTE: every always_comb output gets a value before any branch, so no latch can be inferred.
  always_comb begin
    partial  = {rem, dividend[XLEN-1]};
    ge       = partial >= {1'b0, divisor};
    rem_nxt  = partial[XLEN-1:0];
    if (ge) rem_nxt = XLEN'(partial - {1'b0, divisor});
    quot_nxt = {quot[XLEN-2:0], ge};
  end

  // The last step's values feed the result directly, so no extra cycle is spent.
  assign done = active && (cnt == '0);
  assign res  = rem_sel ? (neg_r ? -rem_nxt : rem_nxt)
                        : (neg_q ? -quot_nxt : quot_nxt);

  // Operand capture on start, then one iteration per cycle down to cnt = 0.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      quot     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      rem_sel  <= 1'b0;
    end else if (start) begin
      active   <= 1'b1;
      cnt      <= SHAMT_W'(XLEN - 1);
      dividend <= a_abs;
      divisor  <= b_abs;
      rem      <= '0;
      quot     <= '0;
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      rem_sel  <= want_rem;
    end else if (active) begin
      dividend <= {dividend[XLEN-2:0], 1'b0};
      rem      <= rem_nxt;
      quot     <= quot_nxt;
      if (cnt == '0) active <= 1'b0;
      else           cnt    <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_md_unit.sv
// alu_md_unit: registered RV32I ALU with ALU-control decode and an optional
// RV32M multiply/divide path behind a valid/ready handshake. One operation
// in flight; results held until accepted.
// Build option: define ALU_MD_M_EXT_EN to include MUL*/DIV*/REM* support.
module alu_md_unit
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input logic          clk,
  input logic          rst,
  alu_md_unit_if.slave bus
);

`ifdef ALU_MD_M_EXT_EN
  localparam logic M_EN = 1'b1;
`else
  localparam logic M_EN = 1'b0;
`endif

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e             state;
  alu_op_e            op;
  logic [XLEN-1:0]    result_q;
  logic               zero_q;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_res;
  logic               accept;
  logic               is_div;
  logic               div_signed;
  logic               b_zero;
  logic               div_corner;
  logic               div_start;
  logic               div_done;
  logic [XLEN-1:0]    div_res;

  assign op         = alu_decode(bus.alu_op, bus.funct3, bus.funct7, bus.opcode, M_EN);
  assign shamt      = bus.b[SHAMT_W-1:0];
  assign accept     = bus.in_valid & bus.in_ready;

  assign is_div     = op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  assign div_signed = op inside {ALU_DIV, ALU_REM};
  assign b_zero     = (bus.b == '0);
  // Divide-by-zero and signed overflow have closed-form answers: no iteration.
  assign div_corner = b_zero | (div_signed & (bus.a == INT_MIN) & (bus.b == '1));
  assign div_start  = accept & is_div & ~div_corner;

`ifdef ALU_MD_M_EXT_EN
  logic [2*XLEN-1:0] a_sx, b_sx, a_zx, b_zx;
  logic [2*XLEN-1:0] p_ss, p_su, p_uu;

  assign a_sx = {{XLEN{bus.a[XLEN-1]}}, bus.a};
  assign b_sx = {{XLEN{bus.b[XLEN-1]}}, bus.b};
  assign a_zx = {{XLEN{1'b0}}, bus.a};
  assign b_zx = {{XLEN{1'b0}}, bus.b};
  // Extending to 2*XLEN before multiplying gives the correct signed product mod 2^(2*XLEN).
  assign p_ss = a_sx * b_sx;
  assign p_su = a_sx * b_zx;
  assign p_uu = a_zx * b_zx;

  alu_divider #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .is_signed (div_signed),
    .want_rem  (op inside {ALU_REM, ALU_REMU}),
    .a         (bus.a),
    .b         (bus.b),
    .done      (div_done),
    .res       (div_res)
  );
`else
  assign div_done = 1'b0;
  assign div_res  = '0;
`endif

  // Single-cycle result: base ALU, multiplies and divide corner cases.
  always_comb begin
    alu_res = '0;
    case (op)
      ALU_ADD:    alu_res = bus.a + bus.b;
      ALU_SUB:    alu_res = bus.a - bus.b;
      ALU_SLL:    alu_res = bus.a << shamt;
      ALU_SLT:    alu_res = XLEN'($signed(bus.a) < $signed(bus.b));
      ALU_SLTU:   alu_res = XLEN'(bus.a < bus.b);
      ALU_XOR:    alu_res = bus.a ^ bus.b;
      ALU_SRL:    alu_res = bus.a >> shamt;
      ALU_SRA:    alu_res = XLEN'($signed(bus.a) >>> shamt);
      ALU_OR:     alu_res = bus.a | bus.b;
      ALU_AND:    alu_res = bus.a & bus.b;
`ifdef ALU_MD_M_EXT_EN
      ALU_MUL:    alu_res = p_uu[XLEN-1:0];
      ALU_MULH:   alu_res = p_ss[2*XLEN-1:XLEN];
      ALU_MULHSU: alu_res = p_su[2*XLEN-1:XLEN];
      ALU_MULHU:  alu_res = p_uu[2*XLEN-1:XLEN];
      // Only consumed when div_corner is set: /0 gives all-ones, overflow gives a.
      ALU_DIV:    alu_res = b_zero ? '1 : bus.a;
      ALU_DIVU:   alu_res = '1;
      ALU_REM,
      ALU_REMU:   alu_res = b_zero ? bus.a : '0;
`endif
      default:    alu_res = '0;
    endcase
  end

  // Control FSM with registered result/zero; HOLD doubles as an accept state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      case (state)
        S_IDLE, S_HOLD: begin
          if (accept) begin
            if (div_start) begin
              state <= S_DIV;
            end else begin
              state    <= S_HOLD;
              result_q <= alu_res;
              zero_q   <= (alu_res == '0);
            end
          end else if (state == S_HOLD && bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        S_DIV: begin
          if (div_done) begin
            state    <= S_HOLD;
            result_q <= div_res;
            zero_q   <= (div_res == '0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE) | ((state == S_HOLD) & bus.out_ready);
  assign bus.out_valid = (state == S_HOLD);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
`ifdef ALU_MD_M_EXT_EN
  assign bus.busy      = (state == S_DIV);
`else
  assign bus.busy      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_md_unit.sv
// Directed self-checking bench for alu_md_unit (XLEN = 32).
// M-extension vectors are compiled in when ALU_MD_M_EXT_EN is defined;
// otherwise funct7 = 0000001 is checked to decode as the base ALU.
module tb_alu_md_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_md_unit_if #(.XLEN(32)) bus ();

  alu_md_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble operands after accept, wait (bounded) for out_valid.
  task automatic run_op(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [6:0] opc, input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output int busy_n);
    bus.alu_op   = aop;
    bus.funct3   = f3;
    bus.funct7   = f7;
    bus.opcode   = opc;
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a        = ~av;
    bus.b        = ~bv;
    lat    = 1;
    busy_n = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.busy) busy_n++;
      tick();
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input logic [1:0] aop, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [6:0] opc, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp_res, input int exp_lat);
    int lat, busy_n;
    run_op(aop, f3, f7, opc, av, bv, lat, busy_n);
    check({tag, ".result"}, bus.result, exp_res);
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".busy_cycles"}, 32'(busy_n), (exp_lat > 1) ? 32'(exp_lat - 1) : 32'd0);
  endtask

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] F0 = 7'b0000000;
  localparam logic [6:0] FA = 7'b0100000;
  localparam logic [6:0] FM = 7'b0000001;

  initial begin
    int lat, busy_n, seen;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.alu_op    = 2'b00;
    bus.funct3    = 3'b000;
    bus.funct7    = F0;
    bus.opcode    = R;
    bus.a         = 32'h0;
    bus.b         = 32'h0;
    tick();
    tick();
    check("reset.out_valid", 32'(bus.out_valid), 32'd0);
    check("reset.result", bus.result, 32'h0);
    check("reset.zero", 32'(bus.zero), 32'd1);
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Base ALU vectors.
    check_op("sub_r", 2'b10, 3'b000, FA, R, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
    check("sub_r.zero", 32'(bus.zero), 32'd0);
    check_op("sra", 2'b10, 3'b101, FA, R, 32'h8000_0000, 32'h24, 32'hF800_0000, 1);
    check_op("srl", 2'b10, 3'b101, F0, R, 32'h8000_0000, 32'h4, 32'h0800_0000, 1);
    check_op("addi_f7alt", 2'b10, 3'b000, FA, I, 32'd5, 32'd7, 32'd12, 1);
    check_op("sll", 2'b10, 3'b001, F0, R, 32'd1, 32'h21, 32'd2, 1);
    check_op("slt", 2'b10, 3'b010, F0, R, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    check_op("sltu", 2'b10, 3'b011, F0, R, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    check("sltu.zero", 32'(bus.zero), 32'd1);
    check_op("and", 2'b10, 3'b111, F0, R, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1);
    check_op("branch_sub", 2'b01, 3'b111, F0, 7'b1100011, 32'd3, 32'd3, 32'd0, 1);
    check("branch_sub.zero", 32'(bus.zero), 32'd1);
    check_op("ld_add", 2'b00, 3'b010, FA, 7'b0000011, 32'hFFFF_FFFF, 32'd2, 32'd1, 1);

`ifdef ALU_MD_M_EXT_EN
    check_op("mul", 2'b10, 3'b000, FM, R, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1);
    check_op("mulh", 2'b10, 3'b001, FM, R, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1);
    check_op("mulhsu", 2'b10, 3'b010, FM, R, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    check_op("mulhu", 2'b10, 3'b011, FM, R, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1);
    check_op("div", 2'b10, 3'b100, FM, R, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    check_op("rem", 2'b10, 3'b110, FM, R, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    check_op("divu", 2'b10, 3'b101, FM, R, 32'd100, 32'd7, 32'd14, 33);
    check_op("remu", 2'b10, 3'b111, FM, R, 32'd100, 32'd7, 32'd2, 33);
    check_op("divu_by0", 2'b10, 3'b101, FM, R, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
    check_op("remu_by0", 2'b10, 3'b111, FM, R, 32'd9, 32'd0, 32'd9, 1);
    check_op("rem_ovf", 2'b10, 3'b110, FM, R, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    check_op("div_ovf", 2'b10, 3'b100, FM, R, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
`else
    check_op("f7m_add", 2'b10, 3'b000, FM, R, 32'd5, 32'd7, 32'd12, 1);
    check_op("f7m_xor", 2'b10, 3'b100, FM, R, 32'd5, 32'd7, 32'd2, 1);
    check_op("f7m_srl", 2'b10, 3'b101, FM, R, 32'h8000_0000, 32'd4, 32'h0800_0000, 1);
`endif

    // Drain to IDLE.
    tick();
    check("drain.out_valid", 32'(bus.out_valid), 32'd0);

    // Back-to-back ADDs, then backpressure.
    bus.alu_op   = 2'b00;
    bus.in_valid = 1'b1;
    bus.a        = 32'd1;
    bus.b        = 32'd1;
    tick();
    check("b2b0.out_valid", 32'(bus.out_valid), 32'd1);
    check("b2b0.result", bus.result, 32'd2);
    bus.a = 32'd2;
    tick();
    check("b2b1.result", bus.result, 32'd3);
    bus.a = 32'd3;
    tick();
    check("b2b2.result", bus.result, 32'd4);
    bus.out_ready = 1'b0;
    bus.a         = 32'd10;
    #1;
    check("stall.in_ready", 32'(bus.in_ready), 32'd0);
    repeat (4) begin
      tick();
      check("stall.result", bus.result, 32'd4);
      check("stall.out_valid", 32'(bus.out_valid), 32'd1);
      check("stall.in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("release.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("release.result", bus.result, 32'd11);
    bus.in_valid = 1'b0;
    tick();
    check("idle.out_valid", 32'(bus.out_valid), 32'd0);

    // Reset while a result is held.
    bus.out_ready = 1'b0;
    run_op(2'b00, 3'b000, F0, R, 32'd1, 32'd1, lat, busy_n);
    check("hold.result", bus.result, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    check("rst_hold.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_hold.result", bus.result, 32'd0);
    check("rst_hold.zero", 32'(bus.zero), 32'd1);

`ifdef ALU_MD_M_EXT_EN
    // Reset in the middle of a divide: nothing may come out afterwards.
    bus.alu_op   = 2'b10;
    bus.funct3   = 3'b101;
    bus.funct7   = FM;
    bus.opcode   = R;
    bus.a        = 32'd100;
    bus.b        = 32'd7;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("div_mid.in_ready", 32'(bus.in_ready), 32'd0);
    repeat (9) tick();
    check("div_mid.busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_div.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_div.busy", 32'(bus.busy), 32'd0);
    check("rst_div.in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    repeat (40) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check("rst_div.stale", 32'(seen), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
